// File: rtl/uart_reg_pkg.sv
// Shared types and constants for the UART register command sequencer.
package uart_reg_pkg;

  localparam int unsigned ADDR_W        = 7;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned CMD_WRITE_BIT = 7;
  localparam logic [DATA_W-1:0] RD_ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_TX_REQ,
    S_TX_HOLD,
    S_TX_WAIT
  } state_e;

  // Inter-byte timeout in clock cycles; 10 bit-times per UART byte.
  function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                 input int unsigned bit_rate,
                                                 input int unsigned n_bytes);
    longint unsigned cyc;
    cyc = 64'(n_bytes) * 64'd10 * 64'(clk_hz) / 64'(bit_rate);
    return 32'(cyc);
  endfunction

endpackage

// File: rtl/uart_reg_ctrl_if.sv
// UART byte stream and register bus seen by the command sequencer.
interface uart_reg_ctrl_if;
  import uart_reg_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_en;
  logic              tx_busy;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_rvalid;
  logic              err;

  // Sequencer side: masters the register bus and the transmitter.
  modport master (
    input  rx_data, rx_valid, tx_busy, reg_rdata, reg_rvalid,
    output tx_data, tx_en, reg_addr, reg_wdata, reg_we, reg_re, err
  );

  // Environment side: UART receiver/transmitter and register bank.
  modport slave (
    output rx_data, rx_valid, tx_busy, reg_rdata, reg_rvalid,
    input  tx_data, tx_en, reg_addr, reg_wdata, reg_we, reg_re, err
  );
endinterface

// File: rtl/uart_reg_timer.sv
// Loadable down-counter; expired is a registered flag raised when the count reaches zero.
module uart_reg_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      if (load) begin
        count <= load_val;
      end else if (en && (count != '0)) begin
        count <= count - W'(1);
      end
      // Goes high in the same cycle the count lands on zero.
      expired <= !load && en && (count <= W'(1));
    end
  end

endmodule

// File: rtl/uart_reg_ctrl.sv
// Parses UART bytes into register write/read commands and returns read data over TX.
module uart_reg_ctrl
  import uart_reg_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned BIT_RATE      = 9600,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter int unsigned RD_WAIT       = 15
) (
  input logic            clk,
  input logic            resetn,
  uart_reg_ctrl_if.master bus
);

  localparam int unsigned TO_CYCLES = timeout_cycles(CLK_HZ, BIT_RATE, TIMEOUT_BYTES);
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);
  localparam int unsigned RD_W      = $clog2(RD_WAIT + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              err_q, err_d;

  logic to_load, to_en, to_expired;
  logic rd_load, rd_en, rd_expired;

  uart_reg_timer #(.W(TO_W)) u_byte_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (to_load),
    .load_val (TO_W'(TO_CYCLES)),
    .en       (to_en),
    .expired  (to_expired)
  );

  // Loaded with RD_WAIT-1 so expiry lands RD_WAIT cycles after the reg_re pulse.
  uart_reg_timer #(.W(RD_W)) u_rd_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (rd_load),
    .load_val (RD_W'(RD_WAIT - 1)),
    .en       (rd_en),
    .expired  (rd_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      err_q     <= err_d;
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    err_d     = 1'b0;
    to_load   = 1'b0;
    to_en     = 1'b0;
    rd_load   = 1'b0;
    rd_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          to_load = 1'b1;
          addr_d  = ADDR_W'(bus.rx_data);
          if (bus.rx_data[CMD_WRITE_BIT]) begin
            state_d = S_WAIT_DATA;
          end else begin
            re_d    = 1'b1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_WAIT_DATA: begin
        to_en = 1'b1;
        // A byte arriving in the expiry cycle still completes the write.
        if (bus.rx_valid) begin
          to_load = 1'b1;
          wdata_d = bus.rx_data;
          we_d    = 1'b1;
          state_d = S_WR;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR: state_d = S_IDLE;
      S_RD_REQ: begin
        rd_load = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rd_en = 1'b1;
        if (bus.reg_rvalid) begin
          tx_data_d = bus.reg_rdata;
          state_d   = S_TX_REQ;
        end else if (rd_expired) begin
          tx_data_d = RD_ERR_BYTE;
          err_d     = 1'b1;
          state_d   = S_TX_REQ;
        end
      end
      S_TX_REQ: begin
        if (!bus.tx_busy) begin
          tx_en_d = 1'b1;
          state_d = S_TX_HOLD;
        end
      end
      S_TX_HOLD: state_d = S_TX_WAIT;
      S_TX_WAIT: begin
        if (!bus.tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // No buffering: bytes arriving mid-transaction are discarded.
    if (bus.rx_valid && (state_q != S_IDLE) && (state_q != S_WAIT_DATA)) begin
      err_d = 1'b1;
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_en     = tx_en_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.err       = err_q;

endmodule
